// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the RV32I program-counter sequencer.
package pc_seq_pkg;

   // Sequencer FSM states.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      WAIT_RESP = 3'd2,
      EXEC      = 3'd3,
      ERROR     = 3'd4
   } pc_state_e;

   // Source of the next PC.
   typedef enum logic [1:0] {
      SEQ    = 2'd0,
      BRANCH = 2'd1,
      JUMP   = 2'd2
   } npc_sel_e;

   // Byte distance between consecutive RV32I instructions.
   localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of instruction-memory, execute-stage and redirect signals around
// the PC sequencer. The master side is the sequencer itself.
interface pc_sequencer_if #(
   parameter int ADDRESS = 32
);
   // instruction memory
   logic               imem_req;
   logic [ADDRESS-1:0] imem_addr;
   logic               imem_gnt;
   logic               imem_rvalid;
   logic [31:0]        imem_rdata;
   // execute stage
   logic               exec_done;
   logic               stall;
   logic [31:0]        instr_out;
   logic               instr_valid;
   // branch / jump resolution
   logic               branch_taken;
   logic [ADDRESS-1:0] branch_target;
   logic               jump;
   logic [ADDRESS-1:0] jump_target;
   // status
   logic [ADDRESS-1:0] pc_out;
   logic               misaligned_err;

   modport master (
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  exec_done, stall,
      input  branch_taken, branch_target, jump, jump_target,
      output imem_req, imem_addr, instr_out, instr_valid,
      output pc_out, misaligned_err
   );

   modport slave (
      output imem_gnt, imem_rvalid, imem_rdata,
      output exec_done, stall,
      output branch_taken, branch_target, jump, jump_target,
      input  imem_req, imem_addr, instr_out, instr_valid,
      input  pc_out, misaligned_err
   );
endinterface

// File: rtl/pc_sequencer_next_pc_sel.sv
// Next-PC priority mux (jump > branch > sequential) with alignment check.
module next_pc_sel
   import pc_seq_pkg::*;
#(
   parameter int ADDRESS = 32
) (
   input  logic [ADDRESS-1:0] pc,
   input  logic               jump,
   input  logic [ADDRESS-1:0] jump_target,
   input  logic               branch_taken,
   input  logic [ADDRESS-1:0] branch_target,
   output logic [ADDRESS-1:0] npc,
   output logic               npc_misaligned
);

   npc_sel_e sel;

   // Pick the redirect source; jump wins over a simultaneous taken branch.
   always_comb begin
      sel = SEQ;
      npc = pc + ADDRESS'(PC_INCR);   // wraps modulo 2^ADDRESS
      if (jump) begin
         sel = JUMP;
         npc = jump_target;
      end else if (branch_taken) begin
         sel = BRANCH;
         npc = branch_target;
      end
   end

   // Only redirect targets can be misaligned; PC+4 from an aligned PC never is.
   assign npc_misaligned = (sel != SEQ) && (npc[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: owns the architectural PC and steps each
// instruction through fetch request, fetch response and execute.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int                 ADDRESS      = 32,
   parameter logic [ADDRESS-1:0] RESET_VECTOR = '0
) (
   input  logic          clk,
   input  logic          rst,     // asynchronous, active low
   pc_sequencer_if.master bus
);

   pc_state_e          state_q, state_d;
   logic [ADDRESS-1:0] pc_q, pc_d;
   logic [31:0]        instr_q, instr_d;
   logic               err_q, err_d;

   logic [ADDRESS-1:0] npc;
   logic               npc_misaligned;

   next_pc_sel #(
      .ADDRESS (ADDRESS)
   ) u_next_pc_sel (
      .pc             (pc_q),
      .jump           (bus.jump),
      .jump_target    (bus.jump_target),
      .branch_taken   (bus.branch_taken),
      .branch_target  (bus.branch_target),
      .npc            (npc),
      .npc_misaligned (npc_misaligned)
   );

   // FSM transitions, instruction capture and PC/error update on EXEC exit.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (bus.imem_gnt) begin
               if (bus.imem_rvalid) begin
                  instr_d = bus.imem_rdata;
                  state_d = EXEC;
               end else begin
                  state_d = WAIT_RESP;
               end
            end
         end
         WAIT_RESP: begin
            if (bus.imem_rvalid) begin
               instr_d = bus.imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            // stall holds the instruction even when exec_done is high
            if (bus.exec_done && !bus.stall) begin
               if (npc_misaligned) begin
                  err_d   = 1'b1;
                  state_d = ERROR;
               end else begin
                  pc_d    = npc;
                  state_d = FETCH;
               end
            end
         end
         ERROR: state_d = ERROR;   // only reset leaves this state
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         instr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         err_q   <= err_d;
      end
   end

   // Outputs decoded from state; the fetch address is the PC, so it cannot
   // move while a request is pending.
   assign bus.pc_out         = pc_q;
   assign bus.imem_req       = (state_q == FETCH);
   assign bus.imem_addr      = pc_q;
   assign bus.instr_out      = instr_q;
   assign bus.instr_valid    = (state_q == EXEC);
   assign bus.misaligned_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected fetch addresses
// and instruction words into queues; a monitor pops and compares them when
// the DUT handshakes a fetch or presents a new instruction.
module tb_pc_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] fetch_q[$];
   logic [31:0] instr_q[$];

   pc_sequencer_if #(.ADDRESS(32)) bus ();

   pc_sequencer #(
      .ADDRESS      (32),
      .RESET_VECTOR (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      logic prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0;
         end else begin
            if (bus.imem_req && bus.imem_gnt) begin
               if (fetch_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL fetch_unexpected: got fetch at 0x%08h, expected none", bus.imem_addr);
               end else begin
                  $display("[%0t] fetch  addr=0x%08h", $time, bus.imem_addr);
                  check("fetch_addr", bus.imem_addr, fetch_q.pop_front());
               end
            end
            if (bus.instr_valid && !prev_valid) begin
               if (instr_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL instr_unexpected: got instr 0x%08h, expected none", bus.instr_out);
               end else begin
                  $display("[%0t] exec   pc=0x%08h instr=0x%08h", $time, bus.pc_out, bus.instr_out);
                  check("instr_out", bus.instr_out, instr_q.pop_front());
               end
            end
            prev_valid = bus.instr_valid;
         end
      end
   endtask

   // One instruction starting with the DUT in FETCH at cur_pc.
   task automatic run(input int gnt_dly, input int rv_dly, input logic [31:0] data,
                      input logic jmp, input logic [31:0] jt,
                      input logic br, input logic [31:0] bt,
                      input int stalls, input logic [31:0] cur_pc,
                      input logic [31:0] exp_pc);
      fetch_q.push_back(cur_pc);
      instr_q.push_back(data);
      // grant wait: redirects here must be ignored
      for (int i = 0; i < gnt_dly; i++) begin
         bus.imem_gnt    = 1'b0;
         bus.imem_rvalid = 1'b0;
         bus.jump        = 1'b1;
         bus.jump_target = 32'h0000_0300;
         bus.exec_done   = 1'b1;
         check("req_held", 32'(bus.imem_req), 32'd1);
         check("addr_held", bus.imem_addr, cur_pc);
         step();
      end
      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = (rv_dly == 0);
      bus.imem_rdata  = (rv_dly == 0) ? data : 32'hDEAD_BEEF;
      step();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      if (rv_dly > 0) begin
         for (int i = 1; i < rv_dly; i++) begin
            check("req_low_wait", 32'(bus.imem_req), 32'd0);
            step();
         end
         check("req_low_wait", 32'(bus.imem_req), 32'd0);
         check("pc_wait", bus.pc_out, cur_pc);
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = data;
         step();
         bus.imem_rvalid = 1'b0;
      end
      bus.jump      = 1'b0;
      bus.exec_done = 1'b0;
      check("exec_valid", 32'(bus.instr_valid), 32'd1);
      check("exec_pc", bus.pc_out, cur_pc);
      // stalled completion attempts
      for (int i = 0; i < stalls; i++) begin
         bus.stall         = 1'b1;
         bus.exec_done     = 1'b1;
         bus.jump          = jmp;
         bus.jump_target   = jt;
         bus.branch_taken  = br;
         bus.branch_target = bt;
         step();
         check("stall_valid", 32'(bus.instr_valid), 32'd1);
         check("stall_pc", bus.pc_out, cur_pc);
      end
      bus.stall         = 1'b0;
      bus.exec_done     = 1'b1;
      bus.jump          = jmp;
      bus.jump_target   = jt;
      bus.branch_taken  = br;
      bus.branch_target = bt;
      step();
      bus.exec_done    = 1'b0;
      bus.jump         = 1'b0;
      bus.branch_taken = 1'b0;
      check("next_pc", bus.pc_out, exp_pc);
      check("valid_drop", 32'(bus.instr_valid), 32'd0);
   endtask

   initial begin
      bus.imem_gnt      = 1'b0;
      bus.imem_rvalid   = 1'b0;
      bus.imem_rdata    = '0;
      bus.exec_done     = 1'b0;
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.jump          = 1'b0;
      bus.jump_target   = '0;
      fork
         monitor();
      join_none

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", bus.pc_out, 32'h0);
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_instr", bus.instr_out, 32'h0);
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_err", 32'(bus.misaligned_err), 32'd0);
      rst_n = 1'b1;
      check("idle_req", 32'(bus.imem_req), 32'd0);
      step();
      check("fetch_req", 32'(bus.imem_req), 32'd1);

      // back-to-back sequential with immediate grant and response
      run(0, 0, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 32'h0, 0, 32'h0000_0000, 32'h0000_0004);
      run(0, 0, 32'h0010_0093, 1'b0, 32'h0, 1'b0, 32'h0, 0, 32'h0000_0004, 32'h0000_0008);
      run(0, 0, 32'h0020_0113, 1'b0, 32'h0, 1'b0, 32'h0, 0, 32'h0000_0008, 32'h0000_000C);
      // grant after 2 cycles, response one cycle later
      run(2, 1, 32'h0030_0193, 1'b0, 32'h0, 1'b0, 32'h0, 0, 32'h0000_000C, 32'h0000_0010);
      // jump and branch together: jump wins
      run(0, 0, 32'h1000_006F, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 0,
          32'h0000_0010, 32'h0000_0100);
      // branch only
      run(0, 2, 32'h2000_0063, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 0,
          32'h0000_0100, 32'h0000_0200);
      // four stalled cycles with exec_done high, then sequential advance
      run(0, 0, 32'h0040_0213, 1'b0, 32'h0, 1'b0, 32'h0, 4, 32'h0000_0200, 32'h0000_0204);
      // jump to the top of the address space, then wrap
      run(0, 0, 32'hFF9F_F06F, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 0,
          32'h0000_0204, 32'hFFFF_FFFC);
      run(0, 0, 32'h0050_0293, 1'b0, 32'h0, 1'b0, 32'h0, 0, 32'hFFFF_FFFC, 32'h0000_0000);
      check("wrap_err", 32'(bus.misaligned_err), 32'd0);
      run(0, 0, 32'h0060_0313, 1'b0, 32'h0, 1'b0, 32'h0, 0, 32'h0000_0000, 32'h0000_0004);
      // misaligned branch target traps, PC held
      run(0, 0, 32'h0E00_0163, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 0,
          32'h0000_0004, 32'h0000_0004);
      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.exec_done   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("err_flag", 32'(bus.misaligned_err), 32'd1);
         check("err_req", 32'(bus.imem_req), 32'd0);
         check("err_valid", 32'(bus.instr_valid), 32'd0);
         check("err_pc", bus.pc_out, 32'h0000_0004);
         step();
      end
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.exec_done   = 1'b0;
      // asynchronous reset clears the trap without a clock edge
      rst_n = 1'b0;
      #1;
      check("arst_pc", bus.pc_out, 32'h0);
      check("arst_err", 32'(bus.misaligned_err), 32'd0);
      check("arst_instr", bus.instr_out, 32'h0);
      check("arst_req", 32'(bus.imem_req), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      run(0, 0, 32'h0070_0393, 1'b0, 32'h0, 1'b0, 32'h0, 0, 32'h0000_0000, 32'h0000_0004);

      step();
      check("fetch_q_empty", 32'(fetch_q.size()), 32'd0);
      check("instr_q_empty", 32'(instr_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
